data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store interface. It accepts one byte-addressed request at a time over a valid/ready handshake and performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) with byte-lane handling and sign/zero extension. After a configurable access latency it returns read data or a completion on a valid/ready response channel. It sits behind the core's data path and replaces the zero-latency data array with a realistic multi-cycle slave.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core data path
// and the memory-side responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data memory slave: one request at a time, byte-lane
// stores, sign/zero-extended loads, response after LATENCY cycles.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          write_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          opWrite;
    logic [2:0]    opFunct3;
    logic [31:0]   opAddr;
    logic [31:0]   opWdata;
    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic          accessErr;
    logic [31:0]   rawWord;
    logic [31:0]   shifted;
    logic [31:0]   loadData;
    logic [3:0]    byteEn;
    logic [31:0]   storeData;

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = bus.req_valid && bus.req_ready;
    // With a single-cycle latency the access happens on the accept edge itself,
    // so the operands come straight off the bus instead of the capture registers.
    assign access   = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == '0));
    assign opWrite  = (state_q == IDLE) ? bus.req_write  : write_q;
    assign opFunct3 = (state_q == IDLE) ? bus.req_funct3 : funct3_q;
    assign opAddr   = (state_q == IDLE) ? bus.req_addr   : addr_q;
    assign opWdata  = (state_q == IDLE) ? bus.req_wdata  : wdata_q;

    always_comb begin
        wordIdx   = opAddr[AW+1:2];
        lane      = opAddr[1:0];
        accessErr = 1'b0;
        if ((opAddr >> (AW + 2)) != 32'd0) accessErr = 1'b1;
        case (opFunct3[1:0])
            2'd1:    if (lane[0]) accessErr = 1'b1;
            2'd2:    if (lane != 2'd0) accessErr = 1'b1;
            2'd3:    accessErr = 1'b1;
            default: ;
        endcase
        if (!opWrite && (opFunct3 == 3'd6)) accessErr = 1'b1;
        if (opWrite && opFunct3[2]) accessErr = 1'b1;

        rawWord = mem_q[wordIdx];
        shifted = rawWord >> {lane, 3'b000};
        case (opFunct3)
            3'd0:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    loadData = {24'd0, shifted[7:0]};
            3'd5:    loadData = {16'd0, shifted[15:0]};
            default: loadData = rawWord;
        endcase

        case (opFunct3[1:0])
            2'd0:    byteEn = 4'b0001 << lane;
            2'd1:    byteEn = 4'b0011 << lane;
            default: byteEn = 4'b1111;
        endcase
        storeData = opWdata << {lane, 3'b000};
    end

    // The array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && opWrite && !accessErr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem_q[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q  <= bus.req_write;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        cnt_q    <= CW'(LATENCY - 1);
                        state_q  <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             state_q <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (access) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= accessErr;
                resp_rdata_q <= (opWrite || accessErr) ? 32'd0 : loadData;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, backpressure and
// reset corner cases, then random traffic against a byte-level memory model.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] refMem [DEPTH];

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory behaviour written as byte arithmetic over the access size.
    function automatic void refAccess(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] d, output logic [31:0] rd, output logic er);
        int unsigned size, off, idx;
        logic [31:0] mask, v;
        size = 1 << f3[1:0];
        off  = a % 4;
        idx  = a / 4;
        rd   = 32'd0;
        er   = (a >= 4 * DEPTH) || (a % size != 0) || (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && f3 >= 3);
        if (er) return;
        if (w) begin
            for (int i = 0; i < int'(size); i++) refMem[idx][(off + i) * 8 +: 8] = d[i * 8 +: 8];
        end else begin
            v = refMem[idx] >> (off * 8);
            if (size < 4) begin
                mask = (32'd1 << (8 * size)) - 32'd1;
                v = v & mask;
                if (f3 < 4 && v[8 * size - 1]) v = v | ~mask;
            end
            rd = v;
        end
    endfunction

    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] expRdata,
                                 input logic expErr, input int hold);
        int guard = 0;
        int lat   = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        checkOutput("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, LAT);
        checkOutput("rdata", bus.resp_rdata, expRdata);
        checkOutput("err", {31'd0, bus.resp_err}, {31'd0, expErr});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            checkOutput("hold_rdata", bus.resp_rdata, expRdata);
            checkOutput("hold_err", {31'd0, bus.resp_err}, {31'd0, expErr});
            checkOutput("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        checkOutput("post_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("post_hs_valid", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    task automatic addVec(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = d; v.expRdata = er; v.expErr = ee;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, d, a;
        logic        ee, w;
        logic [2:0]  f3;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("reset_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("reset_rdata", bus.resp_rdata, 32'd0);
        checkOutput("reset_err", {31'd0, bus.resp_err}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("release_req_ready", {31'd0, bus.req_ready}, 32'd1);

        addVec(1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        addVec(0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        addVec(1, 3'd0, 32'h12,   32'h00000080, 32'h0,        0);
        addVec(0, 3'd2, 32'h10,   32'h0,        32'hDE80BEEF, 0);
        addVec(0, 3'd0, 32'h12,   32'h0,        32'hFFFFFF80, 0);
        addVec(0, 3'd4, 32'h12,   32'h0,        32'h00000080, 0);
        addVec(0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 0);
        addVec(0, 3'd0, 32'h11,   32'h0,        32'hFFFFFFBE, 0);
        addVec(1, 3'd2, 32'h20,   32'h7FFF1234, 32'h0,        0);
        addVec(1, 3'd1, 32'h20,   32'h00008001, 32'h0,        0);
        addVec(0, 3'd5, 32'h20,   32'h0,        32'h00008001, 0);
        addVec(0, 3'd1, 32'h20,   32'h0,        32'hFFFF8001, 0);
        addVec(0, 3'd1, 32'h22,   32'h0,        32'h00007FFF, 0);
        addVec(0, 3'd1, 32'h21,   32'h0,        32'h0,        1);
        addVec(1, 3'd2, 32'h21,   32'h55555555, 32'h0,        1);
        addVec(0, 3'd2, 32'h20,   32'h0,        32'h7FFF8001, 0);
        addVec(0, 3'd2, 32'h1000, 32'h0,        32'h0,        1);
        addVec(0, 3'd3, 32'h10,   32'h0,        32'h0,        1);
        addVec(0, 3'd6, 32'h10,   32'h0,        32'h0,        1);
        addVec(1, 3'd4, 32'h10,   32'h0,        32'h0,        1);
        addVec(0, 3'd2, 32'h10,   32'h0,        32'hDE80BEEF, 0);
        addVec(1, 3'd1, 32'h12,   32'hFFFFA5C3, 32'h0,        0);
        addVec(0, 3'd2, 32'h10,   32'h0,        32'hA5C3BEEF, 0);
        addVec(0, 3'd5, 32'h12,   32'h0,        32'h0000A5C3, 0);
        addVec(0, 3'd2, 32'h12,   32'h0,        32'h0,        1);

        for (int i = 0; i < vecs.size(); i++) begin
            refAccess(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, ee);
            applyStimulus(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdata, vecs[i].expErr, 0);
        end

        // Backpressure: response held for five cycles before it is taken.
        applyStimulus(0, 3'd2, 32'h10, 32'h0, 32'hA5C3BEEF, 0, 5);

        // Reset during WAIT must drop the store before its commit edge.
        applyStimulus(1, 3'd2, 32'h30, 32'h12345678, 32'h0, 0, 0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_wait_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 3'd2, 32'h30, 32'h0, 32'h12345678, 0, 0);

        // Reset while a response is pending clears it without waiting for a clock.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h30;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        checkOutput("resp_pending_valid", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("resp_pending_rdata", bus.resp_rdata, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_resp_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Random traffic over a 16-word window, seeded with known contents first.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = 32'h100 + 32'(4 * i);
            refAccess(1, 3'd2, a, d, rd, ee);
            applyStimulus(1, 3'd2, a, d, rd, ee, 0);
        end
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 63));
            else                           a = 32'h100 + 32'($urandom_range(0, 63));
            refAccess(w, f3, a, d, rd, ee);
            applyStimulus(w, f3, a, d, rd, ee, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
